// File: rtl/aes_pkg.sv
// Shared AES inverse-round definitions: block and key-index widths, round count, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_pkg;

    localparam int NR_DEFAULT = 10;
    localparam int BLK_W      = 128;
    localparam int KIDX_W     = 4;

    typedef logic [BLK_W-1:0]  blk_t;
    typedef logic [KIDX_W-1:0] kidx_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// Request/key/result bundle between a key-schedule owner (master) and the round controller (slave).
// Latency: n/a (wiring only).
// Backpressure: none; start is a request the slave may ignore while busy.
interface aes_inv_round_ctrl_if;
    import aes_pkg::*;

    logic  start;
    blk_t  ct_in;
    blk_t  round_key;
    kidx_t key_idx;
    logic  busy;
    logic  done;
    blk_t  pt_out;

    modport master (
        output start, ct_in, round_key,
        input  key_idx, busy, done, pt_out
    );

    modport slave (
        input  start, ct_in, round_key,
        output key_idx, busy, done, pt_out
    );

endinterface

// File: rtl/aes_inv_round_dp.sv
// Inverse-round datapath: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (AES_INV_SBOX_PIPE_EN adds a post-S-box register).
// Latency: combinational by default; one register stage after InvSubBytes when the pipe is enabled.
// Backpressure: none; the pipe register loads only when sub_en_i is high.
module aes_inv_round_dp
    import aes_pkg::*;
(
`ifdef AES_INV_SBOX_PIPE_EN
    input  logic clk,
    input  logic rst_n,
    input  logic sub_en_i,
`endif
    input  blk_t state_i,
    input  blk_t round_key_i,
    output blk_t round_o,
    output blk_t final_o
);

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = gf_xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // Byte k of the block sits at [127-8k -: 8]; column c holds bytes 4c..4c+3 (row 0 first).
    function automatic blk_t inv_shift_rows(input blk_t s);
        blk_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic blk_t inv_sub_bytes(input blk_t s);
        blk_t o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic blk_t inv_mix_columns(input blk_t s);
        blk_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    blk_t sub_c;
    assign sub_c = inv_sub_bytes(inv_shift_rows(state_i));

`ifdef AES_INV_SBOX_PIPE_EN
    blk_t sub_q;
    blk_t sub_d;

    always_comb sub_d = sub_en_i ? sub_c : sub_q;

    always_ff @(posedge clk) begin
        if (!rst_n) sub_q <= '0;
        else        sub_q <= sub_d;
    end

    assign final_o = sub_q ^ round_key_i;
`else
    assign final_o = sub_c ^ round_key_i;
`endif

    assign round_o = inv_mix_columns(final_o);

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// AES-128 inverse-cipher round controller: FSM, round counter, key index and plaintext register (option: AES_INV_SBOX_PIPE_EN).
// Latency: done NR+2 cycles after the start-accept edge; 2*NR+2 with AES_INV_SBOX_PIPE_EN.
// Backpressure: none; start is ignored while busy or in DONE, accepted again in the first IDLE cycle.
module aes_inv_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_DEFAULT
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_round_ctrl_if.slave  bus
);

    localparam kidx_t NR_K = kidx_t'(NR);

    state_e st_q, st_d;
    blk_t   state_q, state_d;
    blk_t   pt_q, pt_d;
    kidx_t  rnd_q, rnd_d;
    blk_t   dp_round, dp_final;
    logic   phase_last;
    kidx_t  key_idx;
    logic   busy;
    logic   done;

`ifdef AES_INV_SBOX_PIPE_EN
    // Each ROUND/FINAL step takes two cycles: phase 0 loads the S-box register, phase 1 commits.
    logic phase_q, phase_d, sub_en;
    assign phase_last = phase_q;
    assign sub_en     = (st_q == ST_ROUND || st_q == ST_FINAL) && !phase_q;
    assign phase_d    = (st_q == ST_ROUND || st_q == ST_FINAL) ? !phase_q : 1'b0;
`else
    assign phase_last = 1'b1;
`endif

    aes_inv_round_dp u_dp (
`ifdef AES_INV_SBOX_PIPE_EN
        .clk         (clk),
        .rst_n       (rst_n),
        .sub_en_i    (sub_en),
`endif
        .state_i     (state_q),
        .round_key_i (bus.round_key),
        .round_o     (dp_round),
        .final_o     (dp_final)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            state_q <= '0;
            pt_q    <= '0;
            rnd_q   <= '0;
`ifdef AES_INV_SBOX_PIPE_EN
            phase_q <= 1'b0;
`endif
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            pt_q    <= pt_d;
            rnd_q   <= rnd_d;
`ifdef AES_INV_SBOX_PIPE_EN
            phase_q <= phase_d;
`endif
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE:  if (bus.start) st_d = ST_INIT;
            ST_INIT:  st_d = (NR_K == 4'd1) ? ST_FINAL : ST_ROUND;
            ST_ROUND: if (phase_last && rnd_q <= 4'd1) st_d = ST_FINAL;
            ST_FINAL: if (phase_last) st_d = ST_DONE;
            ST_DONE:  st_d = ST_IDLE;
            default:  st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        key_idx = '0;
        busy    = 1'b0;
        done    = 1'b0;
        state_d = state_q;
        pt_d    = pt_q;
        rnd_d   = rnd_q;
        case (st_q)
            ST_IDLE: begin
                if (bus.start) state_d = bus.ct_in;
            end
            ST_INIT: begin
                key_idx = NR_K;
                busy    = 1'b1;
                state_d = state_q ^ bus.round_key;
                rnd_d   = NR_K - 4'd1;
            end
            ST_ROUND: begin
                key_idx = rnd_q;
                busy    = 1'b1;
                if (phase_last) begin
                    state_d = dp_round;
                    if (rnd_q != 4'd0) rnd_d = rnd_q - 4'd1;
                end
            end
            ST_FINAL: begin
                busy = 1'b1;
                if (phase_last) begin
                    state_d = dp_final;
                    pt_d    = dp_final;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.key_idx = key_idx;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.pt_out  = pt_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: known-answer vectors with a cycle-level timing model and a result scoreboard.
module tb_aes_inv_round_ctrl;
    import aes_pkg::*;

    localparam int NR = 10;
`ifdef AES_INV_SBOX_PIPE_EN
    localparam int LAT = 2*NR + 2;
`else
    localparam int LAT = NR + 2;
`endif
    localparam int NV = 6;

    typedef struct {
        logic key_sel;
        blk_t ct;
        blk_t pt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_sel = 1'b0;
    blk_t rka [0:15];
    blk_t rkb [0:15];
    blk_t cur_pt = '0;
    vec_t vecs [NV];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   dones = 0;
    bit   m_act = 1'b0;
    int   m_acc = 0;
    blk_t exp_q [$];

    aes_inv_round_ctrl_if bus ();

    aes_inv_round_ctrl #(.NR(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.round_key = key_sel ? rkb[bus.key_idx] : rka[bus.key_idx];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic kidx_t exp_key(input int t);
`ifdef AES_INV_SBOX_PIPE_EN
        if (t == 0)       return kidx_t'(NR);
        if (t <= 2*NR)    return kidx_t'(NR - (t + 1) / 2);
        return '0;
`else
        if (t <= NR)      return kidx_t'(NR - t);
        return '0;
`endif
    endfunction

    // Acceptance model: an edge accepts start only when the controller is back in IDLE.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            m_act = 1'b0;
            exp_q.delete();
        end else begin
            if (m_act && (cyc - m_acc) >= LAT + 1) m_act = 1'b0;
            if (!m_act && bus.start === 1'b1) begin
                m_act = 1'b1;
                m_acc = cyc;
                exp_q.push_back(cur_pt);
            end
        end
    end

    always @(negedge clk) begin
        int    t;
        kidx_t ek;
        logic  eb, ed;
        t = cyc - m_acc;
        if (m_act && t <= LAT - 1) begin
            eb = (t <= LAT - 2);
            ed = (t == LAT - 1);
            ek = exp_key(t);
        end else begin
            eb = 1'b0;
            ed = 1'b0;
            ek = '0;
        end
        check("busy", 128'(bus.busy), 128'(eb));
        check("done", 128'(bus.done), 128'(ed));
        check("key_idx", 128'(bus.key_idx), 128'(ek));
        if (bus.done === 1'b1) begin
            dones++;
            if (exp_q.size() != 0) check("pt_out", bus.pt_out, exp_q.pop_front());
            else                   check("done_pending", 128'(exp_q.size()), 128'd1);
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 128'(exp_q.size()), 128'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_block(input vec_t v);
        @(negedge clk);
        key_sel    = v.key_sel;
        bus.ct_in  = v.ct;
        cur_pt     = v.pt;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_idle(200);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int d0;
        for (int i = 0; i < 16; i++) begin
            rka[i] = '0;
            rkb[i] = '0;
        end
        rka[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rka[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rka[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rka[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rka[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rka[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rka[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rka[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rka[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rka[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rka[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        rkb[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rkb[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rkb[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rkb[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rkb[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rkb[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rkb[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rkb[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rkb[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rkb[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rkb[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        vecs[0] = '{1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{1'b1, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{1'b1, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a};
        vecs[3] = '{1'b1, 128'hf5d3d58503b9699de785895a96fdbaaf, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
        vecs[4] = '{1'b1, 128'h43b1cd7f598ece23881b00e3ed030688, 128'h30c81c46a35ce411e5fbc1191a0a52ef};
        vecs[5] = '{1'b1, 128'h7b0c785e27e8ad3f8223207104725dd4, 128'hf69f2445df4f9b17ad2b417be66c3710};

        bus.start = 1'b0;
        bus.ct_in = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pt_out", bus.pt_out, '0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_block(vecs[i]);
            check("pt_hold", bus.pt_out, vecs[i].pt);
        end

        // start pulses at cycles 3 and 7 of a decryption must be ignored
        d0 = dones;
        @(negedge clk);
        key_sel   = vecs[0].key_sel;
        bus.ct_in = vecs[0].ct;
        cur_pt    = vecs[0].pt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.ct_in = ~vecs[0].ct;
        cur_pt    = ~vecs[0].pt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.ct_in = vecs[0].ct;
        cur_pt    = vecs[0].pt;
        wait_idle(200);
        check("ignored_start_pt", bus.pt_out, vecs[0].pt);
        check("ignored_start_dones", 128'(dones - d0), 128'd1);

        // reset at cycle 5 abandons the block
        d0 = dones;
        @(negedge clk);
        key_sel   = vecs[1].key_sel;
        bus.ct_in = vecs[1].ct;
        cur_pt    = vecs[1].pt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("pt_after_rst", bus.pt_out, '0);
        rst_n = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        check("rst_no_done", 128'(dones - d0), 128'd0);
        run_block(vecs[0]);
        check("after_rst_pt", bus.pt_out, vecs[0].pt);

        // start held high: second block accepted right after DONE, ct changes while busy are ignored
        d0 = dones;
        @(negedge clk);
        key_sel   = 1'b1;
        bus.ct_in = vecs[2].ct;
        cur_pt    = vecs[2].pt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.ct_in = vecs[3].ct;
        cur_pt    = vecs[3].pt;
        repeat (LAT + 2) @(negedge clk);
        bus.start = 1'b0;
        wait_idle(200);
        check("b2b_dones", 128'(dones - d0), 128'd2);
        check("b2b_pt_hold", bus.pt_out, vecs[3].pt);

        repeat (3) @(negedge clk);
        check("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
